// File: rtl/serial_restoring_divider.sv
// Serial restoring divider: one quotient bit per clock, WIDTH iterations per divide.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division, remainder takes dividend sign).
module serial_restoring_divider #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, ZDIV} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fit;
  logic             last;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] zrem;

  // One restoring step on {R,Q}; r[WIDTH] is always 0 between steps but still forces a fit if set
  always_comb begin
    shifted = {r[WIDTH-1:0], q[WIDTH-1]};
    diff    = shifted - {1'b0, d};
    fit     = r[WIDTH] | (shifted >= {1'b0, d});
    r_next  = fit ? diff : shifted;
    q_next  = {q[WIDTH-2:0], fit};
    last    = (count == CW'(WIDTH - 1));
  end

`ifdef DIV_SIGNED_EN
  logic sq;
  logic sr;

  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    q_fin = sq ? -q_next : q_next;
    r_fin = sr ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
    // q still holds |a| on a zero divide; restoring the sign recovers a
    zrem  = sr ? -q : q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq <= 1'b0;
      sr <= 1'b0;
    end else if (state == IDLE && load) begin
      sq <= a[WIDTH-1] ^ b[WIDTH-1];
      sr <= a[WIDTH-1];
    end
  end
`else
  always_comb begin
    a_mag = a;
    b_mag = b;
    q_fin = q_next;
    r_fin = r_next[WIDTH-1:0];
    zrem  = q;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = (b == '0) ? ZDIV : RUN;
      RUN:  if (last) state_nxt = IDLE;
      ZDIV: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            d           <= b_mag;
            q           <= a_mag;
            r           <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + CW'(1);
          if (last) begin
            quotient  <= q_fin;
            remainder <= r_fin;
            done      <= 1'b1;
          end
        end
        ZDIV: begin
          quotient    <= '1;
          remainder   <= zrem;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
